// File: rtl/tt_mux_ctrl.sv
// tt_mux_ctrl: sequences one-hot project enables (gap, held reset, release) and muxes the shared in/out words
// Ports: clk/rst_n (async active-low); sel_valid/sel_ready/sel_addr host select handshake;
// host_iw -> proj_iw broadcast with gated project reset; ow_bus -> host_ow from the active project;
// proj_ena one-hot enable; active_idx selected index; busy in GAP/RESET; sel_err out-of-range pulse.
module tt_mux_ctrl #(
  parameter int N_PROJ     = 32,
  parameter int SEL_W      = 6,
  parameter int GAP_CYCLES = 2,
  parameter int RST_CYCLES = 4,
  parameter int IW_W       = 18,
  parameter int OW_W       = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  input  logic [SEL_W-1:0]       sel_addr,
  input  logic [IW_W-1:0]        host_iw,
  output logic [IW_W-1:0]        proj_iw,
  output logic [N_PROJ-1:0]      proj_ena,
  input  logic [N_PROJ*OW_W-1:0] ow_bus,
  output logic [OW_W-1:0]        host_ow,
  output logic [SEL_W-1:0]       active_idx,
  output logic                   busy,
  output logic                   sel_err
);
  localparam logic [1:0] S_OFF = 2'd0, S_GAP = 2'd1, S_RST = 2'd2, S_ACT = 2'd3;
  localparam int CNT_MAX = (GAP_CYCLES > RST_CYCLES) ? GAP_CYCLES : RST_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          proj_rst_q;
  logic          accept;
  logic          in_range;
  assign sel_ready = (state == S_OFF) || (state == S_ACT);
  assign busy      = (state == S_GAP) || (state == S_RST);
  assign accept    = sel_valid && sel_ready;
  assign in_range  = 32'(sel_addr) < 32'(N_PROJ);
  assign proj_iw   = {host_iw[IW_W-1:2], host_iw[1] & proj_rst_q, host_iw[0]};
  always_comb host_ow = (state == S_RST || state == S_ACT) ? ow_bus[OW_W*int'(active_idx) +: OW_W] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_OFF;
      cnt        <= '0;
      proj_ena   <= '0;
      proj_rst_q <= 1'b0;
      active_idx <= '0;
      sel_err    <= 1'b0;
    end else begin
      sel_err <= 1'b0;
      if (accept) begin
        proj_ena   <= '0;
        proj_rst_q <= 1'b0;
        sel_err    <= !in_range;
        state      <= in_range ? S_GAP : S_OFF;
        cnt        <= CW'(GAP_CYCLES - 1);
        if (in_range) active_idx <= sel_addr;
      end else if (state == S_GAP && cnt == '0) begin
        state    <= S_RST;
        cnt      <= CW'(RST_CYCLES - 1);
        proj_ena <= N_PROJ'(1) << active_idx;
      end else if (state == S_RST && cnt == '0) begin
        state      <= S_ACT;
        proj_rst_q <= 1'b1;
      end else if (busy) begin
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_tt_mux_ctrl.sv
// tb_tt_mux_ctrl: randomized and directed checks of tt_mux_ctrl against a cycle-age reference model
module tb_tt_mux_ctrl;
  localparam int N = 32, SW = 6, G = 2, R = 4, IW = 18, OW = 24;
  logic clk = 0, rst_n = 0, sel_valid = 0, sel_ready, busy, sel_err;
  logic [SW-1:0] sel_addr = '0, active_idx;
  logic [IW-1:0] host_iw = '0, proj_iw;
  logic [N-1:0] proj_ena;
  logic [N*OW-1:0] ow_bus = '0;
  logic [OW-1:0] host_ow;
  int checks = 0, failures = 0;
  bit m_on = 0, m_err = 0;
  int m_age = 0, m_idx = 0;

  tt_mux_ctrl dut (.clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_addr(sel_addr), .host_iw(host_iw), .proj_iw(proj_iw), .proj_ena(proj_ena),
    .ow_bus(ow_bus), .host_ow(host_ow), .active_idx(active_idx), .busy(busy), .sel_err(sel_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_phase();
    if (!m_on) return 0;
    if (m_age <= G) return 1;
    if (m_age <= G + R) return 2;
    return 3;
  endfunction

  task automatic check_all();
    int ph;
    logic [N*OW-1:0] sh;
    logic en;
    ph = m_phase();
    en = (ph >= 2);
    sh = ow_bus >> (m_idx * OW);
    chk("proj_ena", proj_ena, en ? 64'(N'(1) << m_idx) : 64'd0);
    chk("host_ow", host_ow, en ? 64'(sh[OW-1:0]) : 64'd0);
    chk("sel_ready", sel_ready, (ph == 0 || ph == 3));
    chk("busy", busy, (ph == 1 || ph == 2));
    chk("sel_err", sel_err, m_err);
    chk("active_idx", active_idx, 64'(m_idx));
    chk("proj_iw", proj_iw, {host_iw[IW-1:2], host_iw[1] & (ph == 3), host_iw[0]});
    chk("onehot", $countones(proj_ena) <= 1, 1);
  endtask

  task automatic cycle(input bit v, input int a);
    bit acc;
    sel_valid = v;
    sel_addr = SW'(a);
    host_iw = IW'($urandom);
    for (int k = 0; k < N; k++) ow_bus[k*OW +: OW] = OW'($urandom);
    acc = v && (m_phase() == 0 || m_phase() == 3);
    @(posedge clk);
    m_err = 0;
    if (acc && a < N) begin m_on = 1; m_idx = a; m_age = 1; end
    else if (acc) begin m_on = 0; m_err = 1; end
    else if (m_on && m_age < 1000) m_age++;
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0);
  endtask

  initial begin
    #12 check_all();
    @(negedge clk) rst_n = 1;
    idle(5);
    cycle(1, 5);
    idle(G + R);
    for (int i = 0; i < 3; i++) begin
      sel_valid = 0;
      host_iw = IW'($urandom);
      ow_bus[5*OW +: OW] = 24'hA5A5A5;
      #1 check_all();
      chk("ow_a5", host_ow, 24'hA5A5A5);
      @(posedge clk); #1;
    end
    cycle(1, 31);
    idle(G + R + 2);
    cycle(1, 40);
    idle(2);
    cycle(1, 7);
    cycle(1, 3);
    cycle(1, 3);
    idle(G + R + 2);
    cycle(1, 7);
    idle(G + 1);
    #2 rst_n = 0;
    #1;
    chk("arst_ena", proj_ena, 0);
    chk("arst_busy", busy, 0);
    chk("arst_idx", active_idx, 0);
    chk("arst_ow", host_ow, 0);
    chk("arst_ready", sel_ready, 1);
    chk("arst_iw1", proj_iw[1], 0);
    m_on = 0; m_idx = 0; m_err = 0;
    @(negedge clk) rst_n = 1;
    idle(2);
    cycle(1, 12);
    idle(G + R + 2);
    for (int i = 0; i < 400; i++) cycle($urandom_range(0, 9) < 3, $urandom_range(0, 47));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
